conv_layer_sequencer: RTL and testbench

CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

---
 rtl/featuremap_pkg.sv | 24 ++
 rtl/seq_pix_counter.sv | 28 ++
 rtl/conv_layer_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/featuremap_pkg.sv
// Shared types and frame-size helpers for the convolution layer sequencer.
package featuremap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Padded input pixels and output pixels per filter pass for a given output side
  function automatic int unsigned in_total(input int unsigned width);
    return (width + 2) * (width + 2);
  endfunction

  function automatic int unsigned out_total(input int unsigned width);
    return width * width;
  endfunction

  localparam int unsigned DEF_WIDTH = 56;
  localparam int unsigned IN_TOTAL  = in_total(DEF_WIDTH);
  localparam int unsigned OUT_TOTAL = out_total(DEF_WIDTH);

endpackage

// File: rtl/seq_pix_counter.sv
// Modulo pixel counter: counts inc strobes, flags the terminal value, clr has priority.
module seq_pix_counter #(
  parameter int unsigned TERMINAL = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_last
);

  localparam int unsigned CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [CW-1:0] r_count;

  assign o_last = (r_count == CW'(TERMINAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Sequences filter passes over one conv layer: reads padded input, waits for outputs, flags errors.
// Optional drain watchdog enabled by defining SEQ_TIMEOUT_EN.
module conv_layer_sequencer
  import featuremap_pkg::*;
#(
  parameter int unsigned WIDTH       = 56,
  parameter int unsigned NUM_CH      = 16,
  parameter int unsigned NUM_FILTERS = 16,
  parameter int unsigned TIMEOUT_CYC = 4096,
  localparam int unsigned FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] data_fifo_empty,
  input  logic              out_afull,
  input  logic              valid_out_fm,
  output logic              rdreq,
  output logic [FW-1:0]     filter_idx,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int unsigned IN_TOT  = in_total(WIDTH);
  localparam int unsigned OUT_TOT = out_total(WIDTH);

  seq_state_e r_state, w_next;

  logic          r_busy, r_done, r_frame_err, r_out_done;
  logic [FW-1:0] r_filter;

  logic w_rd, w_in_last, w_out_last, w_out_inc, w_out_fin, w_last_filter;
  logic w_pass_end, w_early, w_in_clr, w_out_clr, w_err_set;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] r_wd;
`endif

  // Read only when every channel has data and downstream has room
  assign w_rd  = (r_state == ST_RUN) && !(|data_fifo_empty) && !out_afull;
  assign rdreq = w_rd;

  assign w_out_inc     = valid_out_fm && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_out_fin     = w_out_inc && w_out_last;
  assign w_last_filter = (r_filter == FW'(NUM_FILTERS - 1));

  seq_pix_counter #(.TERMINAL(IN_TOT)) u_in_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_rd),
    .i_clr  (w_in_clr),
    .o_last (w_in_last)
  );

  seq_pix_counter #(.TERMINAL(OUT_TOT)) u_out_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_out_inc),
    .i_clr  (w_out_clr),
    .o_last (w_out_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_pass_end = 1'b0;
    w_early    = 1'b0;
    w_in_clr   = 1'b0;
    w_out_clr  = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next    = ST_RUN;
          w_in_clr  = 1'b1;
          w_out_clr = 1'b1;
        end
        if (valid_out_fm) begin
          w_err_set = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_rd && w_in_last) begin
          w_in_clr = 1'b1;
          if (r_out_done || w_out_fin) begin
            w_pass_end = 1'b1;
          end else begin
            w_next = ST_DRAIN;
          end
        end else if (w_out_fin) begin
          // All outputs arrived before the input frame finished
          w_early   = 1'b1;
          w_err_set = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_out_fin) begin
          w_pass_end = 1'b1;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (!valid_out_fm && (r_wd == WDW'(TIMEOUT_CYC - 1))) begin
          w_next    = ST_IDLE;
          w_err_set = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        w_next = ST_IDLE;
        if (valid_out_fm) begin
          w_err_set = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (w_pass_end) begin
      w_in_clr  = 1'b1;
      w_out_clr = 1'b1;
      w_next    = w_last_filter ? ST_DONE : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_out_done  <= 1'b0;
      r_filter    <= '0;
    end else begin
      r_busy <= (w_next == ST_RUN) || (w_next == ST_DRAIN);
      r_done <= (w_next == ST_DONE);

      if (w_err_set) begin
        r_frame_err <= 1'b1;
      end else if ((r_state == ST_IDLE) && start) begin
        r_frame_err <= 1'b0;
      end

      if (w_out_clr) begin
        r_out_done <= 1'b0;
      end else if (w_early) begin
        r_out_done <= 1'b1;
      end

      if ((r_state == ST_IDLE) && start) begin
        r_filter <= '0;
      end else if (w_pass_end && !w_last_filter) begin
        r_filter <= r_filter + FW'(1);
      end else if (r_state == ST_DONE) begin
        r_filter <= '0;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Idle cycles spent in DRAIN since the last output strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd <= '0;
    end else if (valid_out_fm || (r_state != ST_DRAIN)) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + WDW'(1);
    end
  end
`endif

  assign busy       = r_busy;
  assign done       = r_done;
  assign frame_err  = r_frame_err;
  assign filter_idx = r_filter;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer (WIDTH=4, NUM_FILTERS=2, NUM_CH=8).
module tb_conv_layer_sequencer;

  localparam int unsigned NCH   = 8;
  localparam int          NREAD = 36;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [NCH-1:0] data_fifo_empty;
  logic           out_afull;
  logic           valid_out_fm;
  logic           rdreq;
  logic [0:0]     filter_idx;
  logic           busy;
  logic           done;
  logic           frame_err;

  conv_layer_sequencer #(
    .WIDTH       (4),
    .NUM_CH      (NCH),
    .NUM_FILTERS (2),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .data_fifo_empty (data_fifo_empty),
    .out_afull       (out_afull),
    .valid_out_fm    (valid_out_fm),
    .rdreq           (rdreq),
    .filter_idx      (filter_idx),
    .busy            (busy),
    .done            (done),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int reads;
    int fidx;
    int dn;
    int ferr;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input int f, input int d, input int e);
    exp_t x;
    x.reads = r; x.fidx = f; x.dn = d; x.ferr = e;
    q.push_back(x);
  endtask

  // One filter pass: reads with optional stalls and in-RUN strobes, then ndrain strobes
  task automatic run_pass(input int vlo, input int vhi, input int ndrain,
                          input bit tog7, input bit afull_win);
    int reads = 0;
    int cyc   = 0;
    while (reads < NREAD && cyc < 400) begin
      data_fifo_empty = (tog7 && cyc[0]) ? NCH'(8'h80) : '0;
      out_afull       = afull_win && (cyc >= 12) && (cyc < 22);
      valid_out_fm    = (cyc >= vlo) && (cyc < vhi);
      #1;
      if (out_afull) chk("afull_blocks_rdreq", int'(rdreq), 0);
      if (rdreq) reads++;
      cyc++;
      tick();
    end
    if (reads < NREAD) chk("pass_read_budget", reads, NREAD);
    data_fifo_empty = '0;
    out_afull       = 1'b0;
    valid_out_fm    = 1'b0;
    for (int i = 0; i < ndrain; i++) begin
      valid_out_fm = 1'b1;
      tick();
    end
    valid_out_fm = 1'b0;
  endtask

  task automatic start_layer();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_layer(input string tag);
    repeat (3) tick();
    chk({tag, "_busy_low"}, int'(busy), 0);
    chk({tag, "_fidx_zero"}, int'(filter_idx), 0);
  endtask

  // Monitor: pass-end events (filter advance or done) pop the scoreboard
  int         pass_reads = 0;
  logic [0:0] prev_fidx  = '0;
  logic       prev_done  = 1'b0;

  always @(negedge clk) begin
    if (rst || start) begin
      pass_reads = 0;
    end else begin
      if (done || ((filter_idx != prev_fidx) && !prev_done)) begin
        if (q.size() == 0) begin
          chk("unexpected_pass_event", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ev_reads", pass_reads, e.reads);
          chk("ev_filter_idx", int'(filter_idx), e.fidx);
          chk("ev_done", int'(done), e.dn);
          chk("ev_frame_err", int'(frame_err), e.ferr);
        end
        pass_reads = 0;
      end
      if ((|data_fifo_empty) || out_afull) chk("stall_rdreq_low", int'(rdreq), 0);
      if (rdreq) pass_reads++;
    end
    prev_fidx = filter_idx;
    prev_done = done;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; data_fifo_empty = '0; out_afull = 1'b0; valid_out_fm = 1'b0;
    repeat (3) tick();
    chk("rst_rdreq", int'(rdreq), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_filter_idx", int'(filter_idx), 0);
    rst = 1'b0;
    tick();

    // Clean layer: two passes, 36 reads and 16 outputs each
    push(NREAD, 1, 0, 0); push(NREAD, 1, 1, 0);
    start_layer();
    chk("start_busy", int'(busy), 1);
    run_pass(0, 0, 16, 1'b0, 1'b0);
    run_pass(0, 0, 16, 1'b0, 1'b0);
    end_layer("clean");

    // Channel 7 empty every other cycle
    push(NREAD, 1, 0, 0); push(NREAD, 1, 1, 0);
    start_layer();
    run_pass(0, 0, 16, 1'b1, 1'b0);
    run_pass(0, 0, 16, 1'b1, 1'b0);
    end_layer("empty7");

    // Downstream almost-full for 10 cycles mid-pass
    push(NREAD, 1, 0, 0); push(NREAD, 1, 1, 0);
    start_layer();
    run_pass(0, 0, 16, 1'b0, 1'b1);
    run_pass(0, 0, 16, 1'b0, 1'b0);
    end_layer("afull");

    // Stray output strobe while idle, cleared by the next start
    valid_out_fm = 1'b1;
    tick();
    valid_out_fm = 1'b0;
    chk("idle_strobe_err", int'(frame_err), 1);
    chk("idle_strobe_busy", int'(busy), 0);
    start_layer();
    chk("start_clears_err", int'(frame_err), 0);

    // Abort after 20 reads
    begin
      int reads = 0;
      int cyc   = 0;
      while (reads < 20 && cyc < 100) begin
        #1;
        if (rdreq) reads++;
        cyc++;
        tick();
      end
      chk("abort_reads", reads, 20);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_rdreq", int'(rdreq), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_filter_idx", int'(filter_idx), 0);
    chk("abort_frame_err", int'(frame_err), 0);
    repeat (4) tick();
    chk("abort_stays_idle", int'(busy), 0);

    // Early outputs in pass 0; final output coincides with final read in pass 1
    push(NREAD, 1, 0, 1); push(NREAD, 1, 1, 1);
    start_layer();
    run_pass(2, 18, 0, 1'b0, 1'b0);
    run_pass(20, 36, 0, 1'b0, 1'b0);
    end_layer("early");

`ifdef SEQ_TIMEOUT_EN
    // Drain watchdog: one output strobe short
    start_layer();
    run_pass(0, 0, 15, 1'b0, 1'b0);
    repeat (7) tick();
    chk("wd_err_before", int'(frame_err), 0);
    chk("wd_busy_before", int'(busy), 1);
    tick();
    chk("wd_err_after", int'(frame_err), 1);
    chk("wd_busy_after", int'(busy), 0);
    chk("wd_no_done", int'(done), 0);
    repeat (3) tick();
`endif

    repeat (3) tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
